// File: rtl/con_window_gen_if.sv
// Pixel-stream / window bus between the pixel source, con_window_gen and the MAC array.
// With CON_LINE_ERR_EN defined the bus also carries line_err and err_cnt.
interface con_window_gen_if #(
  parameter int IMA = 8,
  parameter int K   = 7
);
  logic [IMA-1:0]     ima;
  logic               enable;
  logic               frame_start_in;
  logic               line_start_in;
  logic               frame_end_in;
  logic [IMA*K*K-1:0] win;
  logic               out_valid;
  logic               frame_start_out;
  logic               line_start_out;
  logic               frame_end_out;
`ifdef CON_LINE_ERR_EN
  logic               line_err;
  logic [7:0]         err_cnt;
`endif

  modport master (
    output ima, enable, frame_start_in, line_start_in, frame_end_in,
    input  win, out_valid, frame_start_out, line_start_out, frame_end_out
`ifdef CON_LINE_ERR_EN
    , input line_err, err_cnt
`endif
  );

  modport slave (
    input  ima, enable, frame_start_in, line_start_in, frame_end_in,
    output win, out_valid, frame_start_out, line_start_out, frame_end_out
`ifdef CON_LINE_ERR_EN
    , output line_err, err_cnt
`endif
  );
endinterface

// File: rtl/con_window_gen.sv
// Sliding KxK window generator over a raster pixel stream, K-1 line buffers deep.
// Optional macro CON_LINE_ERR_EN adds line_err / err_cnt line-length checking.
//
// state  | meaning
// S_HOLD | after reset or frame_end: counters frozen, buffers written, no windows
// S_RUN  | inside a frame: col/row track each beat, windows emitted
module con_window_gen #(
  parameter int IMA    = 8,
  parameter int LINE_W = 32,
  parameter int K      = 7,
  parameter int CW     = 10
) (
  input logic              clk,
  input logic              rst_n,
  con_window_gen_if.slave  bus
);

  localparam int            AW     = $clog2(LINE_W);
  localparam int            WW     = IMA * K * K;
  localparam logic [CW-1:0] KM1_C  = CW'(K - 1);
  localparam logic [CW-1:0] LAST_C = CW'(LINE_W - 1);

  typedef enum logic {S_HOLD, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic            wrap_q, wrap_d;
  logic            first_q, first_d;
  logic [WW-1:0]   win_q, win_d;
  logic            out_valid_q, out_valid_d;
  logic            fs_out_q, fs_out_d;
  logic            ls_out_q, ls_out_d;
  logic            fe_out_q, fe_out_d;
`ifdef CON_LINE_ERR_EN
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
`endif

  logic [CW-1:0]   pix_col, pix_row;
  logic [AW-1:0]   lb_addr;
  logic            live;
  logic [IMA-1:0]  lb_q   [K-1][LINE_W];
  logic [IMA-1:0]  lb_rd  [K-1];
  logic [IMA-1:0]  col_new[K];

  assign lb_addr = pix_col[AW-1:0];

  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      lb_rd[j] = lb_q[j][lb_addr];
    end
  end

  // New window column, top (oldest line) to bottom (current pixel).
  always_comb begin
    col_new[K-1] = bus.ima;
    for (int j = 0; j < K - 1; j++) begin
      col_new[K-2-j] = lb_rd[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wrap_d      = wrap_q;
    first_d     = first_q;
    win_d       = win_q;
    out_valid_d = 1'b0;
    fs_out_d    = 1'b0;
    ls_out_d    = 1'b0;
    fe_out_d    = 1'b0;
    pix_col     = col_q;
    pix_row     = row_q;
    live        = 1'b0;
`ifdef CON_LINE_ERR_EN
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
`endif

    if (bus.enable) begin
      live = bus.frame_start_in || (state_q == S_RUN);

      if (bus.frame_start_in) begin
        pix_col = '0;
        pix_row = '0;
      end else if ((state_q == S_RUN) && (bus.line_start_in || wrap_q)) begin
        // A missing line_start after a full line is treated as if it were present.
        pix_col = '0;
        pix_row = (row_q == KM1_C) ? row_q : row_q + CW'(1);
      end

      if (live) begin
        row_d = pix_row;
        if (pix_col == LAST_C) begin
          col_d  = pix_col;
          wrap_d = 1'b1;
        end else begin
          col_d  = pix_col + CW'(1);
          wrap_d = 1'b0;
        end
      end

      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[IMA*(r*K+c) +: IMA] = win_q[IMA*(r*K+c+1) +: IMA];
        end
        win_d[IMA*(r*K+K-1) +: IMA] = col_new[r];
      end

      out_valid_d = live && (pix_row >= KM1_C) && (pix_col >= KM1_C);
      ls_out_d    = out_valid_d && (pix_col == KM1_C);
      fs_out_d    = ls_out_d && first_q;
      fe_out_d    = bus.frame_end_in;

      if (bus.frame_start_in) begin
        first_d = 1'b1;
      end else if (fs_out_d) begin
        first_d = 1'b0;
      end

      if (bus.frame_end_in) begin
        state_d = S_HOLD;
      end else if (bus.frame_start_in) begin
        state_d = S_RUN;
      end

`ifdef CON_LINE_ERR_EN
      if (bus.frame_start_in) begin
        err_cnt_d = '0;
      end else if (state_q == S_RUN) begin
        err_d = (bus.line_start_in && !wrap_q && (col_q != '0)) ||
                (wrap_q && !bus.line_start_in);
        if (err_d && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      col_q       <= '0;
      row_q       <= '0;
      wrap_q      <= 1'b0;
      first_q     <= 1'b0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      fs_out_q    <= 1'b0;
      ls_out_q    <= 1'b0;
      fe_out_q    <= 1'b0;
`ifdef CON_LINE_ERR_EN
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wrap_q      <= wrap_d;
      first_q     <= first_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      fs_out_q    <= fs_out_d;
      ls_out_q    <= ls_out_d;
      fe_out_q    <= fe_out_d;
`ifdef CON_LINE_ERR_EN
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  // Line buffers are not reset; out_valid gating keeps stale contents hidden.
  always_ff @(posedge clk) begin
    if (rst_n && bus.enable) begin
      lb_q[0][lb_addr] <= bus.ima;
      for (int j = 1; j < K - 1; j++) begin
        lb_q[j][lb_addr] <= lb_q[j-1][lb_addr];
      end
    end
  end

  assign bus.win             = win_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.frame_start_out = fs_out_q;
  assign bus.line_start_out  = ls_out_q;
  assign bus.frame_end_out   = fe_out_q;
`ifdef CON_LINE_ERR_EN
  assign bus.line_err        = err_q;
  assign bus.err_cnt         = err_cnt_q;
`endif

endmodule
